// File: rtl/alu_arb_pkg.sv
// Shared types and default widths for the ALU arbiter slice.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 4;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU shared by all requesters of alu_arbiter.
module alu
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] input_a,
  input  logic [DATA_W-1:0] input_b,
  input  logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      4'd0:    result = input_a + input_b;
      4'd1:    result = input_a - input_b;
      4'd2:    result = input_a & input_b;
      4'd3:    result = input_a | input_b;
      4'd4:    result = input_a ^ input_b;
      4'd5:    result = ~input_a;
      4'd6:    result = input_a << 1;
      4'd7:    result = input_a >> 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module alu_rr_pick
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences NUM_REQ requesters through one shared alu instance
// and returns each result on a single tagged response channel.
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = alu_arb_pkg::DATA_W,
  parameter int unsigned OP_W    = alu_arb_pkg::OP_W,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [15:0]               op_count
);

  import alu_arb_pkg::*;

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [15:0]         op_count_q, op_count_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any_req;
  logic [DATA_W-1:0]   alu_result;

  alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  alu u_alu (
    .input_a (a_q),
    .input_b (b_q),
    .alu_op  (op_q),
    .result  (alu_result)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d      = req_a[gnt_idx*DATA_W +: DATA_W];
          b_d      = req_b[gnt_idx*DATA_W +: DATA_W];
          op_d     = req_op[gnt_idx*OP_W +: OP_W];
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = alu_result;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

  // State resets to IDLE, so the grant must also be masked while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE)) ? gnt : '0;
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;

endmodule
